// File: rtl/unpack_pkg.sv
// Shared constants and width helpers for the byte unpacking stream.
// Consumed by byte_unpack_stream and modq_reduce12.
package unpack_pkg;

  localparam logic [11:0] KYBER_Q = 12'd3329;

  // Bits needed to represent every value in 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/modq_reduce12.sv
// Single conditional subtract of q from a 12-bit value; purely combinational.
// Only instantiated when UNPACK_MODQ_EN is defined.
module modq_reduce12
  import unpack_pkg::*;
(
  input  logic [11:0] raw,
  output logic [11:0] reduced_c
);

  assign reduced_c = (raw >= KYBER_Q) ? raw - KYBER_Q : raw;

endmodule

// File: rtl/byte_unpack_stream.sv
// Streaming byte-to-word unpacker: LSB-first bit accumulator with frame delimiting.
// Define UNPACK_MODQ_EN to reduce 12-bit words modulo q on the output.
module byte_unpack_stream
  import unpack_pkg::*;
#(
  parameter int unsigned IN_BYTES = 1,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned N_OUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_BYTES*8-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last
);

  localparam int unsigned IN_W   = IN_BYTES * 8;
  localparam int unsigned ACC_W  = IN_W + OUT_W;
  localparam int unsigned FILL_W = cnt_w(ACC_W);
  localparam int unsigned WCNT_W = cnt_w(N_OUT - 1);

  localparam logic [FILL_W-1:0] OUT_W_F   = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] IN_W_F    = FILL_W'(IN_W);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(N_OUT - 1);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_base;
  logic [FILL_W-1:0] fill_next;
  logic [WCNT_W-1:0] wcnt;
  logic              push;
  logic              pop;

  // Handshake flags come only from registered state, so out_ready never reaches in_ready.
  assign out_valid = (fill >= OUT_W_F);
  assign out_last  = out_valid & (wcnt == WCNT_LAST);
  assign in_ready  = (fill <= OUT_W_F) & ~out_last;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Consume the low word first, then append the new beat right above the remaining bits.
  always_comb begin
    acc_base  = acc;
    fill_base = fill;
    if (pop) begin
      acc_base  = acc >> OUT_W;
      fill_base = fill - OUT_W_F;
    end
    acc_next  = acc_base;
    fill_next = fill_base;
    if (push) begin
      acc_next  = acc_base | (ACC_W'(in_data) << fill_base);
      fill_next = fill_base + IN_W_F;
    end
  end

  // Popping the last word of a frame discards any leftover bits.
  always_ff @(posedge clk) begin
    if (rst || (pop && out_last)) begin
      acc  <= '0;
      fill <= '0;
      wcnt <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      if (pop) begin
        wcnt <= wcnt + WCNT_W'(1);
      end
    end
  end

`ifdef UNPACK_MODQ_EN
  generate
    if (OUT_W == 12) begin : g_modq
      modq_reduce12 u_modq (
        .raw       (acc[11:0]),
        .reduced_c (out_data)
      );
    end else begin : g_raw
      assign out_data = acc[OUT_W-1:0];
    end
  endgenerate
`else
  assign out_data = acc[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_byte_unpack_stream.sv
// Bench for byte_unpack_stream: bit-queue reference model checked every cycle,
// directed literal scenarios, a 2-byte/1-word-frame instance, and random traffic.
module tb_byte_unpack_stream;

  localparam int unsigned OUT_W = 12;
  localparam int unsigned N_OUT = 2;
`ifdef UNPACK_MODQ_EN
  localparam logic [11:0] FF_WORD = 12'h2FE;
`else
  localparam logic [11:0] FF_WORD = 12'hFFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_last;

  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [11:0] out_data2;
  logic        out_last2;

  bit          mq[$];
  int          wc = 0;
  bit          armed = 0;
  logic [12:0] pop_log[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  byte_unpack_stream #(.IN_BYTES(1), .OUT_W(OUT_W), .N_OUT(N_OUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  byte_unpack_stream #(.IN_BYTES(2), .OUT_W(12), .N_OUT(1)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .out_last  (out_last2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] reduce(input logic [11:0] x);
`ifdef UNPACK_MODQ_EN
    int v;
    v = int'(x);
    return (v >= 3329) ? 12'(v - 3329) : x;
`else
    return x;
`endif
  endfunction

  // Oldest queued bit is the word LSB.
  function automatic logic [11:0] model_word();
    logic [11:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < mq.size()) w[i] = mq[i];
    end
    return w;
  endfunction

  // Compare outputs with the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit          ev;
    bit          el;
    bit          er;
    logic [11:0] ew;
    if (armed) begin
      ev = (mq.size() >= OUT_W);
      el = ev && (wc == N_OUT - 1);
      er = (mq.size() <= OUT_W) && !el;
      ew = reduce(model_word());
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_last", 32'(out_last), 32'(el));
      check("in_ready", 32'(in_ready), 32'(er));
      if (ev) check("out_data", 32'(out_data), 32'(ew));
      if (rst) begin
        mq.delete();
        wc = 0;
      end else begin
        if (ev && out_ready) begin
          pop_log.push_back({el, ew});
          for (int i = 0; i < OUT_W; i++) void'(mq.pop_front());
          if (el) begin
            mq.delete();
            wc = 0;
          end else begin
            wc++;
          end
        end
        if (in_valid && er) begin
          for (int i = 0; i < 8; i++) mq.push_back(in_data[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !done; i++) begin
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got stalled expected accepted for byte %0h", b);
    end
  endtask

  task automatic expect_log(input string name, input int k, input logic [12:0] exp);
    check(name, (k < pop_log.size()) ? 32'(pop_log[k]) : 32'hDEAD_0000, 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    step();
    step();
    armed = 1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;

    // Two-word frame from EF CD AB.
    out_ready = 1'b1;
    base = pop_log.size();
    push_byte(8'hEF); push_byte(8'hCD); push_byte(8'hAB);
    idle(4);
    expect_log("ex1_word0", base, {1'b0, 12'hDEF});
    expect_log("ex1_word1", base + 1, {1'b1, 12'hABC});
    check("ex1_empty_valid", 32'(out_valid), 0);
    check("ex1_empty_ready", 32'(in_ready), 1);

    // All-ones bytes, optionally reduced.
    base = pop_log.size();
    push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF);
    idle(4);
    expect_log("ff_word0", base, {1'b0, FF_WORD});
    expect_log("ff_word1", base + 1, {1'b1, FF_WORD});

    // Backpressure holds the first word and stalls input at 16 buffered bits.
    out_ready = 1'b0;
    push_byte(8'hEF); push_byte(8'hCD);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(out_data), 32'h0DEF);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_stall_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_after_pop_valid", 32'(out_valid), 0);
    check("bp_after_pop_ready", 32'(in_ready), 1);
    push_byte(8'hAB);
    check("bp_last_data", 32'(out_data), 32'h0ABC);
    check("bp_last_flag", 32'(out_last), 1);
    check("bp_last_stall", 32'(in_ready), 0);
    out_ready = 1'b1;
    idle(2);

    // Reset mid-frame drops the buffered bits.
    out_ready = 1'b0;
    push_byte(8'hEF); push_byte(8'hCD);
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(in_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    base = pop_log.size();
    push_byte(8'hAB); push_byte(8'h00); push_byte(8'h55);
    idle(4);
    expect_log("midrst_word0", base, {1'b0, 12'h0AB});
    expect_log("midrst_word1", base + 1, {1'b1, 12'h550});

    // Two-byte beats, one-word frames: surplus nibble of the beat is discarded.
    check("s2_rst_ready", 32'(in_ready2), 1);
    in_valid2 = 1'b1; in_data2 = 16'hABCD;
    step();
    in_valid2 = 1'b0;
    check("s2_valid", 32'(out_valid2), 1);
    check("s2_data", 32'(out_data2), 32'h0BCD);
    check("s2_last", 32'(out_last2), 1);
    check("s2_stall", 32'(in_ready2), 0);
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    check("s2_flushed_valid", 32'(out_valid2), 0);
    check("s2_flushed_ready", 32'(in_ready2), 1);
    in_valid2 = 1'b1; in_data2 = 16'h0123;
    step();
    in_valid2 = 1'b0;
    check("s2_next_data", 32'(out_data2), 32'h0123);
    check("s2_next_last", 32'(out_last2), 1);
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;

    // Random traffic with occasional resets, then a full-rate stretch.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = (i >= 2400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
